// File: rtl/data_cache_pkg.sv
// Shared geometry, FSM state type and address field helpers for the data cache.
package cache_pkg;
    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int NUM_SETS    = 8;
    localparam int BLOCK_BYTES = 4;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int IDX_W       = $clog2(NUM_SETS);
    localparam int TAG_W       = ADDR_W - IDX_W - OFF_W;
    localparam int LINE_W      = 8 * BLOCK_BYTES;
    localparam int MADDR_W     = ADDR_W - OFF_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] off_of(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction
endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller: sequences victim write-back, block fetch and line update.
//  state     | meaning
//  IDLE      | serving hits; a miss leaves here
//  WRITEBACK | dirty victim being written to memory
//  FETCH     | new block being read from memory
//  UPDATE    | refill lands in the arrays; request retried next cycle
module dcache_ctrl_fsm
    import cache_pkg::*;
(
    input  logic   CLK,
    input  logic   RESET,
    input  logic   req,
    input  logic   hit,
    input  logic   victim_dirty,
    input  logic   mem_busywait,
    output state_t state,
    output logic   busywait,
    output logic   mem_read,
    output logic   mem_write
);
    state_t next_state;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busywait   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (state)
            IDLE: begin
                if (req && !hit) begin
                    busywait   = 1'b1;
                    next_state = victim_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busywait  = 1'b1;
                mem_write = 1'b1;
                if (!mem_busywait) next_state = FETCH;
            end
            FETCH: begin
                busywait = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) next_state = UPDATE;
            end
            UPDATE: begin
                busywait   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // A reset abandons any memory transfer in the very cycle it is seen.
        if (RESET) begin
            busywait  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache between CPU and memory.
// Optional hit/miss counters are built when DATA_CACHE_STATS_EN is defined.
module data_cache
    import cache_pkg::*;
(
    input  logic               CLK,
    input  logic               RESET,
    input  logic               read,
    input  logic               write,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  writedata,
    output logic [DATA_W-1:0]  readdata,
    output logic               busywait,
    output logic               mem_read,
    output logic               mem_write,
    output logic [MADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0]  mem_writedata,
    input  logic [LINE_W-1:0]  mem_readdata,
`ifdef DATA_CACHE_STATS_EN
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count,
`endif
    input  logic               mem_busywait
);
    logic [LINE_W-1:0]  line_arr [NUM_SETS];
    logic [TAG_W-1:0]   tag_arr  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;

    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic             hit;
    logic             req;
    logic             store_hit;
    state_t           state;

    assign idx       = idx_of(address);
    assign off       = off_of(address);
    assign req       = read | write;
    assign hit       = valid[idx] && (tag_arr[idx] == tag_of(address));
    assign readdata  = line_arr[idx][{off, 3'b000} +: 8];
    assign store_hit = (state == IDLE) && write && hit && !RESET;

    dcache_ctrl_fsm u_ctrl (
        .CLK          (CLK),
        .RESET        (RESET),
        .req          (req),
        .hit          (hit),
        .victim_dirty (valid[idx] & dirty[idx]),
        .mem_busywait (mem_busywait),
        .state        (state),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_write    (mem_write)
    );

    always_comb begin
        mem_address   = '0;
        mem_writedata = '0;
        if (mem_write) begin
            mem_address   = {tag_arr[idx], idx};
            mem_writedata = line_arr[idx];
        end else if (mem_read) begin
            mem_address = {tag_of(address), idx};
        end
    end

    // Data and tags are deliberately left uncleared; valid bits gate their use.
    always_ff @(posedge CLK) begin
        if (state == UPDATE) begin
            line_arr[idx] <= mem_readdata;
            tag_arr[idx]  <= tag_of(address);
        end else if (store_hit) begin
            line_arr[idx][{off, 3'b000} +: 8] <= writedata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == UPDATE) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    // The retry that follows a refill is the same request, so it is not a second hit.
    logic refilled;
    logic idle_req;
    assign idle_req = (state == IDLE) && req;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            refilled   <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == UPDATE)    refilled <= 1'b1;
            else if (state == IDLE) refilled <= 1'b0;
            if (idle_req && hit && !refilled && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (idle_req && !hit && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic vs a memory-view model.
module tb_data_cache;
    import cache_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET, read, write;
    logic [7:0]  address, writedata, readdata;
    logic        busywait, mem_read, mem_write, mem_busywait;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata, mem_readdata;
`ifdef DATA_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    data_cache dut (
        .CLK(CLK), .RESET(RESET), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata),
`ifdef DATA_CACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .mem_busywait(mem_busywait)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: main memory bytes, CPU-visible bytes, and which block each set holds.
    logic [7:0] mem_b [256];
    logic [7:0] view  [256];
    logic       vld   [8];
    logic       drt   [8];
    logic [2:0] tg    [8];
    int         exp_hits = 0;
    int         exp_miss = 0;

    function automatic logic [31:0] mem_blk(input logic [7:0] base);
        return {mem_b[base + 8'd3], mem_b[base + 8'd2], mem_b[base + 8'd1], mem_b[base]};
    endfunction

    function automatic logic [31:0] view_blk(input logic [7:0] base);
        return {view[base + 8'd3], view[base + 8'd2], view[base + 8'd1], view[base]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            vld[i] = 1'b0;
            drt[i] = 1'b0;
        end
        for (int i = 0; i < 256; i++) view[i] = mem_b[i];
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // One CPU request starting at a negedge; wb_lat/fe_lat < 0 pick a random memory latency.
    task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                          input int wb_lat, input int fe_lat, input bit drop,
                          output logic [7:0] rd, output logic [31:0] wb_data);
        logic [2:0] s;
        logic [2:0] t;
        logic [7:0] vbase, fbase;
        bit         hit_e, wb_e;
        int         lat;
        s = a[4:2];
        t = a[7:5];
        hit_e = vld[s] && (tg[s] == t);
        wb_e  = !hit_e && vld[s] && drt[s];
        vbase = {tg[s], s, 2'b00};
        fbase = {t, s, 2'b00};
        rd = '0;
        wb_data = '0;
        read = !wr; write = wr; address = a; writedata = d;
        if (hit_e) exp_hits++; else exp_miss++;
        #1;
        if (!hit_e) begin
            check("miss_stall", 32'(busywait), 32'd1);
            @(negedge CLK);
            if (wb_e) begin
                lat = (wb_lat < 0) ? int'($urandom_range(0, 3)) : wb_lat;
                wb_data = view_blk(vbase);
                for (int i = 0; i <= lat; i++) begin
                    mem_busywait = (i < lat);
                    #1;
                    check("wb_mem_write", 32'(mem_write), 32'd1);
                    check("wb_addr", 32'(mem_address), 32'({tg[s], s}));
                    check("wb_data", mem_writedata, view_blk(vbase));
                    check("wb_stall", 32'(busywait), 32'd1);
                    @(negedge CLK);
                end
                for (int b = 0; b < 4; b++) mem_b[vbase + 8'(b)] = view[vbase + 8'(b)];
            end
            lat = (fe_lat < 0) ? int'($urandom_range(0, 3)) : fe_lat;
            for (int i = 0; i <= lat; i++) begin
                if (drop && i == 0) begin read = 1'b0; write = 1'b0; end
                mem_busywait = (i < lat);
                mem_readdata = (i < lat) ? $urandom : mem_blk(fbase);
                #1;
                check("fe_mem_read", 32'(mem_read), 32'd1);
                check("fe_mem_write", 32'(mem_write), 32'd0);
                check("fe_addr", 32'(mem_address), 32'({t, s}));
                check("fe_stall", 32'(busywait), 32'd1);
                @(negedge CLK);
            end
            mem_busywait = 1'($urandom_range(0, 1));
            #1;
            check("upd_stall", 32'(busywait), 32'd1);
            check("upd_mem_read", 32'(mem_read), 32'd0);
            @(negedge CLK);
            vld[s] = 1'b1;
            drt[s] = 1'b0;
            tg[s]  = t;
            #1;
            if (drop) begin
                check("drop_idle", 32'(busywait), 32'd0);
                check("drop_mem_read", 32'(mem_read), 32'd0);
                @(negedge CLK);
                return;
            end
        end
        check("hit_nostall", 32'(busywait), 32'd0);
        if (!wr) begin
            check("rdata", 32'(readdata), 32'(view[a]));
            rd = readdata;
        end
        @(negedge CLK);
        read = 1'b0; write = 1'b0;
        if (wr) begin
            view[a] = d;
            drt[s]  = 1'b1;
        end
    endtask

    logic [7:0]  rd;
    logic [31:0] wbd;
    logic [7:0]  ra, rdat;

    initial begin
        RESET = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        mem_busywait = 1'b0; mem_readdata = '0;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'($urandom);
        mem_b[4] = 8'hAA; mem_b[5] = 8'hBB; mem_b[6] = 8'hCC; mem_b[7] = 8'hDD;
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_busywait", 32'(busywait), 32'd0);
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_mem_wdata", mem_writedata, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("idle_busywait", 32'(busywait), 32'd0);
        @(negedge CLK);

        access(1'b0, 8'h05, 8'h00, -1, -1, 1'b0, rd, wbd);
        check("t1_readdata", 32'(rd), 32'hBB);
        access(1'b0, 8'h06, 8'h00, -1, -1, 1'b0, rd, wbd);
        check("t2_readdata", 32'(rd), 32'hCC);
        access(1'b1, 8'h04, 8'h5A, -1, -1, 1'b0, rd, wbd);
        access(1'b0, 8'h24, 8'h00, -1, -1, 1'b0, rd, wbd);
        check("t3_wb_data", wbd, 32'hDDCCBB5A);
        access(1'b0, 8'h30, 8'h00, -1, 5, 1'b0, rd, wbd);
        access(1'b1, 8'hFF, 8'h3C, -1, -1, 1'b0, rd, wbd);
        access(1'b0, 8'hFF, 8'h00, -1, -1, 1'b0, rd, wbd);
        check("lastbyte", 32'(rd), 32'h3C);
        access(1'b1, 8'h7E, 8'h11, 2, 1, 1'b1, rd, wbd);

        // Reset in the middle of a dirty write-back.
        access(1'b1, 8'h25, 8'h77, -1, -1, 1'b0, rd, wbd);
        read = 1'b1; address = 8'h05; mem_busywait = 1'b1;
        @(negedge CLK);
        #1;
        check("t5_in_wb", 32'(mem_write), 32'd1);
        RESET = 1'b1;
        #1;
        check("t5_rst_mem_write", 32'(mem_write), 32'd0);
        check("t5_rst_busywait", 32'(busywait), 32'd0);
        read = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        #1;
        check("t5_idle_busywait", 32'(busywait), 32'd0);
        check("t5_idle_mem_write", 32'(mem_write), 32'd0);
        check("t5_idle_mem_read", 32'(mem_read), 32'd0);
        @(negedge CLK);
        access(1'b0, 8'h04, 8'h00, -1, -1, 1'b0, rd, wbd);
        check("t5_data_lost", 32'(rd), 32'h5A);

        for (int n = 0; n < 300; n++) begin
            ra   = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(0, 127));
            rdat = 8'($urandom);
            access(1'($urandom_range(0, 1)), ra, rdat, -1, -1,
                   $urandom_range(0, 15) == 0, rd, wbd);
        end

`ifdef DATA_CACHE_STATS_EN
        #1;
        check("hit_count", 32'(hit_count), 32'(exp_hits));
        check("miss_count", 32'(miss_count), 32'(exp_miss));
        for (int n = 0; n < 65540; n++) begin
            read = 1'b1; address = 8'hFF;
            @(negedge CLK);
            read = 1'b0;
        end
        #1;
        check("hit_saturate", 32'(hit_count), 32'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
